sram_like_slave: RTL

- Memory-side responder for the CPU's sram-like bus (req/addr_ok/data_ok). Used in next-lab upgrades of the inst/data ports, and as the bench memory for them.
- Holds a word-addressed memory array.
- Accepts one request per cycle and answers in order after a fixed latency.
- Tracks up to QDEPTH outstanding transactions.

---
 rtl/sram_like_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sram_like_slave.sv
// sram_like_slave: memory-side responder for the sram-like bus (req/addr_ok/data_ok).
// A word-addressed array answers every accepted request in order, exactly
// LATENCY cycles after its address handshake, with up to QDEPTH in flight.
// Optional feature: define SRAM_LIKE_RAND_STALL_EN to add LFSR-driven random
// addr_ok stalls (about 25%) for stressing the master's req-holding logic.
module sram_like_slave #(
    parameter int AW      = 10,  // word-index bits, memory holds 2^AW words
    parameter int LATENCY = 2,   // handshake edge to data_ok, 1..15
    parameter int QDEPTH  = 4    // outstanding transactions, 1..16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    localparam logic [3:0]    LAT   = 4'(LATENCY);
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
    localparam logic [PW-1:0] PMAX  = PW'(QDEPTH - 1);

    // Backing store and per-entry response payload / due-timers.
    logic [31:0] mem     [2**AW];
    logic [31:0] q_data  [QDEPTH];
    logic [3:0]  q_timer [QDEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] widx;
    logic          push;
    logic          pop;
    logic          stall;

    // size is informational and the byte offset / high address bits alias away.
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

    assign widx = addr[AW+1:2];

    // Pointers wrap modulo QDEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PMAX) ? '0 : p + 1'b1;
    endfunction

`ifdef SRAM_LIKE_RAND_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // addr_ok comes only from registered state (and reset), never from req.
    assign addr_ok = !reset && (count < QFULL) && !stall;
    assign push    = req && addr_ok;
    // Fixed latency and in-order issue mean only the head can ever be due.
    assign pop     = (count != '0) && (q_timer[rd_ptr] == 4'd1);

    // Byte-merged writes and read sampling at the handshake edge.
    // NOTE: the memory array and queue payload carry no reset; only control state does.
    always_ff @(posedge clk) begin
        if (push) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb[i]) begin
                        mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
                q_data[wr_ptr] <= 32'h0;
            end else begin
                q_data[wr_ptr] <= mem[widx];
            end
        end
    end

    // Queue control, due-timers and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_ok <= 1'b0;
            rdata   <= 32'h0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_timer[i] <= 4'd0;
            end
        end else begin
            data_ok <= pop;
            rdata   <= pop ? q_data[rd_ptr] : 32'h0;

            for (int i = 0; i < QDEPTH; i++) begin
                if (q_timer[i] > 4'd1) begin
                    q_timer[i] <= q_timer[i] - 4'd1;
                end
            end

            // NOTE: the last non-blocking assignment to a timer wins, so the
            // pop-clear and push-load below override the decrement above.
            if (pop) begin
                q_timer[rd_ptr] <= 4'd0;
                rd_ptr          <= next_ptr(rd_ptr);
            end
            if (push) begin
                q_timer[wr_ptr] <= LAT;
                wr_ptr          <= next_ptr(wr_ptr);
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
